tnet_cmd_ctrl: RTL and testbench

TNET_CMD_CTRL -- requirements
Module: tnet_cmd_ctrl

---
 rtl/tnet_cmd_ctrl.sv | 145 ++++++++++++++
 tb/tb_tnet_cmd_ctrl.sv | 324 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/tnet_cmd_ctrl.sv
// Command controller: turns a register strobe into a valid/ready command,
// then waits for a response, a timeout or an abort and reports through TNET_STATUS.
module tnet_cmd_ctrl #(
  parameter logic [15:0] TOUT_DEF = 16'd1000
) (
  input  logic        ps_aclk,
  input  logic        ps_areset,
  input  logic [31:0] TNET_CTRL,
  input  logic [31:0] TNET_CFG,
  input  logic [15:0] TNET_ADDR,
  input  logic [15:0] TNET_LEN,
  input  logic [31:0] REG_AXI_DT1,
  input  logic [31:0] REG_AXI_DT2,
  input  logic [31:0] REG_AXI_DT3,
  output logic        cmd_valid_o,
  input  logic        cmd_ready_i,
  output logic [4:0]  cmd_op_o,
  output logic [15:0] cmd_addr_o,
  output logic [15:0] cmd_len_o,
  output logic [95:0] cmd_dt_o,
  input  logic        rsp_valid_i,
  input  logic [1:0]  rsp_err_i,
  input  logic [31:0] rsp_dt1_i,
  input  logic [31:0] rsp_dt2_i,
  output logic [31:0] TNET_W_DT1,
  output logic [31:0] TNET_W_DT2,
  output logic [31:0] TNET_STATUS,
  output logic        busy_o
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  logic [1:0]  state;
  logic        strb_prev;
  logic [15:0] tout_q;
  logic [15:0] wait_cnt;
  logic [15:0] cmd_cnt;
  logic [1:0]  err_code;
  logic        done_f;
  logic        tout_f;
  logic        err_f;
  logic        ovr_f;
  logic        abort_f;

  logic        strb_rise;
  logic        abort_req;
  logic        tout_hit;
  logic        unused_bits;

  assign strb_rise   = TNET_CTRL[0] & ~strb_prev;
  assign busy_o      = (state == ST_ISSUE) || (state == ST_WAIT);
  assign abort_req   = TNET_CTRL[31] & busy_o;
  // Fires in the WAIT cycle whose increment would make the counter equal the limit.
  assign tout_hit    = ((wait_cnt + 16'd1) == tout_q);
  assign unused_bits = ^{TNET_CTRL[30:6], TNET_CFG[31:16]};

  assign TNET_STATUS = {cmd_cnt, 3'b000, cmd_op_o, abort_f, ovr_f, err_code,
                        err_f, tout_f, done_f, busy_o};

  always_ff @(posedge ps_aclk) begin
    if (ps_areset) begin
      state       <= ST_IDLE;
      strb_prev   <= 1'b1;
      cmd_valid_o <= 1'b0;
      cmd_op_o    <= '0;
      cmd_addr_o  <= '0;
      cmd_len_o   <= '0;
      cmd_dt_o    <= '0;
      tout_q      <= '0;
      wait_cnt    <= '0;
      cmd_cnt     <= '0;
      TNET_W_DT1  <= '0;
      TNET_W_DT2  <= '0;
      err_code    <= '0;
      done_f      <= 1'b0;
      tout_f      <= 1'b0;
      err_f       <= 1'b0;
      ovr_f       <= 1'b0;
      abort_f     <= 1'b0;
    end else begin
      strb_prev <= TNET_CTRL[0];
      if (strb_rise && (state != ST_IDLE)) begin
        ovr_f <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (strb_rise) begin
            cmd_op_o    <= TNET_CTRL[5:1];
            cmd_addr_o  <= TNET_ADDR;
            cmd_len_o   <= TNET_LEN;
            cmd_dt_o    <= {REG_AXI_DT3, REG_AXI_DT2, REG_AXI_DT1};
            tout_q      <= (TNET_CFG[15:0] == 16'd0) ? TOUT_DEF : TNET_CFG[15:0];
            done_f      <= 1'b0;
            tout_f      <= 1'b0;
            err_f       <= 1'b0;
            err_code    <= '0;
            ovr_f       <= 1'b0;
            abort_f     <= 1'b0;
            cmd_valid_o <= 1'b1;
            state       <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (abort_req) begin
            cmd_valid_o <= 1'b0;
            abort_f     <= 1'b1;
            state       <= ST_IDLE;
          end else if (cmd_ready_i) begin
            cmd_valid_o <= 1'b0;
            wait_cnt    <= '0;
            state       <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          // Priority: abort, then response, then timeout.
          if (abort_req) begin
            abort_f <= 1'b1;
            state   <= ST_IDLE;
          end else if (rsp_valid_i) begin
            TNET_W_DT1 <= rsp_dt1_i;
            TNET_W_DT2 <= rsp_dt2_i;
            err_code   <= rsp_err_i;
            err_f      <= (rsp_err_i != 2'd0);
            state      <= ST_DONE;
          end else if (tout_hit) begin
            tout_f <= 1'b1;
            state  <= ST_DONE;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        ST_DONE: begin
          done_f  <= 1'b1;
          cmd_cnt <= cmd_cnt + 16'd1;
          state   <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tnet_cmd_ctrl.sv
// Bench for tnet_cmd_ctrl: table of directed transactions, hand-driven corner
// sequences and random transactions checked against a transaction-level model.
module tb_tnet_cmd_ctrl;

  logic        clk = 1'b0;
  logic        ps_areset;
  logic [31:0] TNET_CTRL, TNET_CFG;
  logic [15:0] TNET_ADDR, TNET_LEN;
  logic [31:0] REG_AXI_DT1, REG_AXI_DT2, REG_AXI_DT3;
  logic        cmd_valid_o, cmd_ready_i;
  logic [4:0]  cmd_op_o;
  logic [15:0] cmd_addr_o, cmd_len_o;
  logic [95:0] cmd_dt_o;
  logic        rsp_valid_i;
  logic [1:0]  rsp_err_i;
  logic [31:0] rsp_dt1_i, rsp_dt2_i;
  logic [31:0] TNET_W_DT1, TNET_W_DT2, TNET_STATUS;
  logic        busy_o;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] m_cnt;
  logic [31:0] m_w1, m_w2;

  typedef struct {
    logic [4:0]  op;
    logic [15:0] addr;
    logic [15:0] len;
    logic [15:0] cfg;
    logic [31:0] d1, d2, d3;
    int          rdy_dly;
    int          rsp_dly;
    logic [1:0]  rerr;
    logic [31:0] r1, r2;
    int          ek;
    logic        etout;
    logic [1:0]  ecode;
    logic [15:0] ecnt;
    logic [31:0] ew1, ew2;
  } vec_t;

  vec_t tbl[6];

  tnet_cmd_ctrl #(.TOUT_DEF(16'd1000)) dut (
    .ps_aclk(clk), .ps_areset(ps_areset),
    .TNET_CTRL(TNET_CTRL), .TNET_CFG(TNET_CFG),
    .TNET_ADDR(TNET_ADDR), .TNET_LEN(TNET_LEN),
    .REG_AXI_DT1(REG_AXI_DT1), .REG_AXI_DT2(REG_AXI_DT2), .REG_AXI_DT3(REG_AXI_DT3),
    .cmd_valid_o(cmd_valid_o), .cmd_ready_i(cmd_ready_i),
    .cmd_op_o(cmd_op_o), .cmd_addr_o(cmd_addr_o), .cmd_len_o(cmd_len_o),
    .cmd_dt_o(cmd_dt_o),
    .rsp_valid_i(rsp_valid_i), .rsp_err_i(rsp_err_i),
    .rsp_dt1_i(rsp_dt1_i), .rsp_dt2_i(rsp_dt2_i),
    .TNET_W_DT1(TNET_W_DT1), .TNET_W_DT2(TNET_W_DT2),
    .TNET_STATUS(TNET_STATUS), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [95:0] act, input logic [95:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mk_status(input logic [15:0] cnt, input logic [4:0] op,
                                            input logic ab, input logic ov,
                                            input logic [1:0] code, input logic tout,
                                            input logic done, input logic busy);
    return {cnt, 3'b000, op, ab, ov, code, (code != 2'd0), tout, done, busy};
  endfunction

  // Transaction-level prediction: who finishes first, response or timeout.
  function automatic vec_t predict(input vec_t v);
    vec_t r;
    int   tl;
    logic rsp_first;
    r  = v;
    tl = (v.cfg == 16'd0) ? 1000 : int'(v.cfg);
    rsp_first = (v.rsp_dly >= 0) && (v.rsp_dly < tl);
    r.ek    = rsp_first ? v.rsp_dly : tl - 1;
    r.etout = !rsp_first;
    r.ecode = rsp_first ? v.rerr : 2'd0;
    r.ecnt  = m_cnt + 16'd1;
    r.ew1   = rsp_first ? v.r1 : m_w1;
    r.ew2   = rsp_first ? v.r2 : m_w2;
    return r;
  endfunction

  // Starts at a negedge with the DUT idle and the strobe low; ends idle.
  task automatic run_txn(input vec_t v);
    int done_k;
    TNET_CTRL   = {1'b0, 25'd0, v.op, 1'b1};
    TNET_CFG    = {16'h0000, v.cfg};
    TNET_ADDR   = v.addr;
    TNET_LEN    = v.len;
    REG_AXI_DT1 = v.d1;
    REG_AXI_DT2 = v.d2;
    REG_AXI_DT3 = v.d3;
    cmd_ready_i = 1'b0;
    step();
    TNET_CTRL[0] = 1'b0;
    TNET_ADDR    = 16'h0001;
    TNET_LEN     = ~v.len;
    REG_AXI_DT1  = ~v.d1;
    TNET_CFG     = 32'h0000_0002;
    chk("issue_valid", {95'd0, cmd_valid_o}, 96'd1);
    chk("issue_op", {91'd0, cmd_op_o}, {91'd0, v.op});
    chk("issue_addr", {80'd0, cmd_addr_o}, {80'd0, v.addr});
    chk("issue_len", {80'd0, cmd_len_o}, {80'd0, v.len});
    chk("issue_dt", cmd_dt_o, {v.d3, v.d2, v.d1});
    for (int i = 0; i < v.rdy_dly; i++) begin
      rsp_valid_i = 1'b1;
      rsp_dt1_i   = $urandom();
      rsp_dt2_i   = $urandom();
      step();
      chk("stall_valid", {95'd0, cmd_valid_o}, 96'd1);
      chk("stall_addr", {80'd0, cmd_addr_o}, {80'd0, v.addr});
    end
    rsp_valid_i = 1'b0;
    cmd_ready_i = 1'b1;
    step();
    cmd_ready_i = 1'b0;
    chk("wait_valid_low", {95'd0, cmd_valid_o}, 96'd0);
    chk("wait_busy", {95'd0, busy_o}, 96'd1);
    done_k = -1;
    for (int k = 0; k < 1100; k++) begin
      rsp_valid_i = (k == v.rsp_dly);
      rsp_err_i   = v.rerr;
      rsp_dt1_i   = v.r1;
      rsp_dt2_i   = v.r2;
      step();
      rsp_valid_i = 1'b0;
      if (!busy_o) begin
        done_k = k;
        break;
      end
    end
    chk("done_cycle", 96'(done_k), 96'(v.ek));
    step();
    chk("status", {64'd0, TNET_STATUS},
        {64'd0, mk_status(v.ecnt, v.op, 1'b0, 1'b0, v.ecode, v.etout, 1'b1, 1'b0)});
    chk("w_dt1", {64'd0, TNET_W_DT1}, {64'd0, v.ew1});
    chk("w_dt2", {64'd0, TNET_W_DT2}, {64'd0, v.ew2});
    m_cnt = v.ecnt;
    m_w1  = v.ew1;
    m_w2  = v.ew2;
  endtask

  initial begin
    vec_t v;
    tbl[0] = '{5'd5, 16'h1234, 16'h0010, 16'h0000, 32'h1111_0001, 32'h2222_0002, 32'h3333_0003,
               0, 3, 2'd0, 32'h0000_CAFE, 32'h0000_BEEF, 3, 1'b0, 2'd0, 16'd1, 32'h0000_CAFE, 32'h0000_BEEF};
    tbl[1] = '{5'd3, 16'h1234, 16'h0020, 16'h0000, 32'h0000_00A0, 32'h0000_00B0, 32'h0000_00C0,
               10, 0, 2'd0, 32'h0000_1111, 32'h0000_2222, 0, 1'b0, 2'd0, 16'd2, 32'h0000_1111, 32'h0000_2222};
    tbl[2] = '{5'd7, 16'h0055, 16'h0030, 16'h0004, 32'h0101_0101, 32'h0202_0202, 32'h0303_0303,
               1, -1, 2'd0, 32'h9999_9999, 32'h8888_8888, 3, 1'b1, 2'd0, 16'd3, 32'h0000_1111, 32'h0000_2222};
    tbl[3] = '{5'd8, 16'h0100, 16'h0040, 16'h0004, 32'hAAAA_0000, 32'hBBBB_0000, 32'hCCCC_0000,
               0, 3, 2'd1, 32'h0000_3333, 32'h0000_4444, 3, 1'b0, 2'd1, 16'd4, 32'h0000_3333, 32'h0000_4444};
    tbl[4] = '{5'd31, 16'hFFFF, 16'h0000, 16'h000A, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0001,
               2, 1, 2'd2, 32'h0000_5555, 32'h0000_6666, 1, 1'b0, 2'd2, 16'd5, 32'h0000_5555, 32'h0000_6666};
    tbl[5] = '{5'd0, 16'h0000, 16'hFFFF, 16'h0001, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0F0F_0F0F,
               0, -1, 2'd3, 32'h0000_7777, 32'h0000_8888, 0, 1'b1, 2'd0, 16'd6, 32'h0000_5555, 32'h0000_6666};

    ps_areset   = 1'b1;
    TNET_CTRL   = 32'h0000_0001;
    TNET_CFG    = '0;
    TNET_ADDR   = '0;
    TNET_LEN    = '0;
    REG_AXI_DT1 = '0;
    REG_AXI_DT2 = '0;
    REG_AXI_DT3 = '0;
    cmd_ready_i = 1'b0;
    rsp_valid_i = 1'b0;
    rsp_err_i   = '0;
    rsp_dt1_i   = '0;
    rsp_dt2_i   = '0;
    m_cnt = '0;
    m_w1  = '0;
    m_w2  = '0;

    // Reset with the strobe already high: must not trigger afterwards.
    repeat (3) step();
    ps_areset = 1'b0;
    step();
    chk("rst_valid", {95'd0, cmd_valid_o}, 96'd0);
    chk("rst_status", {64'd0, TNET_STATUS}, 96'd0);
    chk("rst_wdt1", {64'd0, TNET_W_DT1}, 96'd0);
    chk("rst_dt", cmd_dt_o, 96'd0);
    repeat (2) step();
    chk("no_trig_high_after_rst", {94'd0, busy_o, cmd_valid_o}, 96'd0);
    TNET_CTRL = '0;
    step();

    foreach (tbl[i]) run_txn(tbl[i]);
    m_cnt = 16'd6;
    m_w1  = 32'h0000_5555;
    m_w2  = 32'h0000_6666;

    // Second strobe edge during WAIT: overrun, single command.
    TNET_CTRL   = {1'b0, 25'd0, 5'd9, 1'b1};
    TNET_CFG    = 32'd20;
    cmd_ready_i = 1'b1;
    step();
    TNET_CTRL[0] = 1'b0;
    step();
    cmd_ready_i  = 1'b0;
    TNET_CTRL[0] = 1'b1;
    step();
    TNET_CTRL[0] = 1'b0;
    rsp_valid_i  = 1'b1;
    rsp_err_i    = 2'd0;
    rsp_dt1_i    = 32'h0000_7A7A;
    rsp_dt2_i    = 32'h0000_7B7B;
    step();
    rsp_valid_i = 1'b0;
    step();
    m_cnt = m_cnt + 16'd1;
    m_w1  = 32'h0000_7A7A;
    m_w2  = 32'h0000_7B7B;
    chk("ovr_status", {64'd0, TNET_STATUS},
        {64'd0, mk_status(m_cnt, 5'd9, 1'b0, 1'b1, 2'd0, 1'b0, 1'b1, 1'b0)});
    repeat (2) step();
    chk("ovr_single_cmd", {94'd0, busy_o, cmd_valid_o}, 96'd0);

    // Abort in WAIT with a same-cycle response: response discarded.
    TNET_CTRL   = {1'b0, 25'd0, 5'd4, 1'b1};
    cmd_ready_i = 1'b1;
    step();
    TNET_CTRL[0] = 1'b0;
    step();
    cmd_ready_i   = 1'b0;
    TNET_CTRL[31] = 1'b1;
    rsp_valid_i   = 1'b1;
    rsp_dt1_i     = 32'hDEAD_0001;
    step();
    TNET_CTRL[31] = 1'b0;
    chk("abw_status", {64'd0, TNET_STATUS},
        {64'd0, mk_status(m_cnt, 5'd4, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)});
    chk("abw_wdt1", {64'd0, TNET_W_DT1}, {64'd0, m_w1});
    rsp_dt1_i = 32'hBAD0_BAD0;
    step();
    rsp_valid_i = 1'b0;
    chk("idle_rsp_ignored", {64'd0, TNET_W_DT1}, {64'd0, m_w1});

    // Abort in ISSUE beats a same-cycle handshake.
    TNET_CTRL = {1'b0, 25'd0, 5'd6, 1'b1};
    step();
    TNET_CTRL   = 32'h8000_0000;
    cmd_ready_i = 1'b1;
    step();
    TNET_CTRL   = '0;
    cmd_ready_i = 1'b0;
    chk("abi_valid", {95'd0, cmd_valid_o}, 96'd0);
    chk("abi_status", {64'd0, TNET_STATUS},
        {64'd0, mk_status(m_cnt, 5'd6, 1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0)});
    step();
    chk("abi_no_wait", {95'd0, busy_o}, 96'd0);

    // Command counter wrap.
    force dut.cmd_cnt = 16'hFFFF;
    step();
    release dut.cmd_cnt;
    m_cnt = 16'hFFFF;
    step();
    v = '{5'd17, 16'h0A0A, 16'h0B0B, 16'd8, 32'h1, 32'h2, 32'h3,
          1, 2, 2'd0, 32'h0000_0E0E, 32'h0000_0F0F, 0, 1'b0, 2'd0, 16'd0, 32'd0, 32'd0};
    run_txn(predict(v));

    // Randomized transactions against the model.
    for (int n = 0; n < 40; n++) begin
      v.op      = 5'($urandom());
      v.addr    = 16'($urandom());
      v.len     = 16'($urandom());
      v.d1      = $urandom();
      v.d2      = $urandom();
      v.d3      = $urandom();
      v.rdy_dly = int'($urandom_range(0, 4));
      v.rerr    = 2'($urandom());
      v.r1      = $urandom();
      v.r2      = $urandom();
      if ($urandom_range(0, 5) == 0) begin
        v.cfg     = 16'd0;
        v.rsp_dly = int'($urandom_range(0, 5));
      end else begin
        v.cfg     = 16'($urandom_range(1, 12));
        v.rsp_dly = ($urandom_range(0, 3) == 0) ? -1 : int'($urandom_range(0, 14));
      end
      run_txn(predict(v));
    end

    // Reset asserted while a command is in ISSUE.
    TNET_CTRL = {1'b0, 25'd0, 5'd2, 1'b1};
    TNET_ADDR = 16'h4321;
    step();
    TNET_CTRL = '0;
    chk("pre_rst_valid", {95'd0, cmd_valid_o}, 96'd1);
    ps_areset = 1'b1;
    step();
    chk("mid_rst_valid", {95'd0, cmd_valid_o}, 96'd0);
    chk("mid_rst_status", {64'd0, TNET_STATUS}, 96'd0);
    chk("mid_rst_addr", {80'd0, cmd_addr_o}, 96'd0);
    chk("mid_rst_wdt", {TNET_W_DT2, TNET_W_DT1, 32'd0}, 96'd0);
    ps_areset = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
